// File: rtl/board_io_ctrl.sv
// board_io_ctrl: board-level I/O front end for the SimpleCPU core.
//
// The block takes raw button pins and cleans them up. Each pin goes through a
// synchroniser and a debouncer, and the block reports clean levels with
// one-cycle press and release pulses. It also builds a stretched system reset
// from reset_n or a chosen button. Finally it drives an LED bank with a
// selectable pin polarity and a global PWM brightness.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset_n        in   synchronous active-low reset
//   pb_in          in   [NUM_PB]     raw asynchronous button pins
//   pb_level       out  [NUM_PB]     debounced level, 1 = pressed
//   pb_press       out  [NUM_PB]     one-cycle pulse when pb_level rises
//   pb_release     out  [NUM_PB]     one-cycle pulse when pb_level falls
//   sys_reset      out               active-high reset to the core
//   led_in         in   [LED_WIDTH]  logical LED state, 1 = lit
//   led_brightness in   [PWM_BITS]   global PWM duty
//   led_out        out  [LED_WIDTH]  LED pins, board polarity
module board_io_ctrl #(
    parameter int NUM_PB            = 4,
    parameter int LED_WIDTH         = 8,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int RESET_PB          = 0,
    parameter int RESET_HOLD_CYCLES = 16,
    parameter int PB_ACTIVE_LOW     = 1,
    parameter int LED_ACTIVE_LOW    = 1,
    parameter int PWM_BITS          = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_PB-1:0]    pb_in,
    output logic [NUM_PB-1:0]    pb_level,
    output logic [NUM_PB-1:0]    pb_press,
    output logic [NUM_PB-1:0]    pb_release,
    output logic                 sys_reset,
    input  logic [LED_WIDTH-1:0] led_in,
    input  logic [PWM_BITS-1:0]  led_brightness,
    output logic [LED_WIDTH-1:0] led_out
);

    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);

    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES);
    // Pin level of a released button. XOR with it maps pins to pressed = 1.
    localparam logic [NUM_PB-1:0]    PB_IDLE   = {NUM_PB{(PB_ACTIVE_LOW != 0)}};
    localparam logic [LED_WIDTH-1:0] LED_OFF   = {LED_WIDTH{(LED_ACTIVE_LOW != 0)}};

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [NUM_PB-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PB-1:0] sync_val;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; blocking assignments here would collapse the chain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: these arrays are flop banks, not RAM, so every element is
            // reset; a RAM-style array would normally be left unreset.
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= PB_IDLE;
            end
        end else begin
            sync_q[0] <= pb_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1] ^ PB_IDLE;

    // ------------------------------------------------------------------
    // Debounce and event pulses
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  db_cnt [NUM_PB];
    logic [NUM_PB-1:0] differ;
    logic [NUM_PB-1:0] accept;

    assign differ = sync_val ^ pb_level;

    // A channel accepts its new level on the edge after it has differed for
    // DEBOUNCE_CYCLES consecutive cycles. The counter therefore stops at
    // DEBOUNCE_CYCLES-1 and never wraps.
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_PB; i++) begin
            accept[i] = differ[i] && (db_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PB; i++) begin
                db_cnt[i] <= '0;
            end
            pb_level   <= '0;
            pb_press   <= '0;
            pb_release <= '0;
        end else begin
            for (int i = 0; i < NUM_PB; i++) begin
                db_cnt[i] <= (differ[i] && !accept[i]) ? db_cnt[i] + CNT_W'(1) : '0;
            end
            pb_level   <= pb_level ^ accept;
            // A channel only accepts when its level differs, so the press and
            // release pulses are mutually exclusive per channel.
            pb_press   <= accept & sync_val;
            pb_release <= accept & ~sync_val;
        end
    end

    // ------------------------------------------------------------------
    // Reset generator
    // ------------------------------------------------------------------
    // hold_cnt counts the cycles since the cause cleared and saturates at
    // RESET_HOLD_CYCLES. Any cause pulls it back to zero, which restarts the
    // stretch from the beginning.
    logic [HOLD_W-1:0] hold_cnt;
    logic              cause;

    assign cause = !reset_n || pb_level[RESET_PB];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (pb_level[RESET_PB]) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // Combinational OR so that a button press raises sys_reset in the same
    // cycle that pb_level shows it.
    assign sys_reset = cause || (hold_cnt != HOLD_LAST);

    // ------------------------------------------------------------------
    // LED PWM
    // ------------------------------------------------------------------
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                lit;

    // All-ones brightness forces the LEDs fully on. Without this term the
    // counter compare would leave one dark cycle per period.
    assign lit = (&led_brightness) || (pwm_cnt < led_brightness);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            led_out <= LED_OFF;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            led_out <= (led_in & {LED_WIDTH{lit}}) ^ LED_OFF;
        end
    end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Testbench for board_io_ctrl.
//
// This bench builds with a short debounce of 8 cycles and a reset hold of
// 4 cycles. A behavioural model follows the rules on pin history, cycles since
// reset and cycles since the last reset cause. A negedge compare process checks
// every output against that model. Directed sequences then pin the key
// latencies and counts to hand-computed constants.
module tb_board_io_ctrl;

    localparam int NPB = 4;
    localparam int LW  = 8;
    localparam int SS  = 2;
    localparam int DB  = 8;
    localparam int HLD = 4;
    localparam int PB  = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NPB-1:0] pb_in;
    logic [NPB-1:0] pb_level;
    logic [NPB-1:0] pb_press;
    logic [NPB-1:0] pb_release;
    logic           sys_reset;
    logic [LW-1:0]  led_in;
    logic [PB-1:0]  led_brightness;
    logic [LW-1:0]  led_out;

    int checks   = 0;
    int failures = 0;

    board_io_ctrl #(
        .NUM_PB            (NPB),
        .LED_WIDTH         (LW),
        .SYNC_STAGES       (SS),
        .DEBOUNCE_CYCLES   (DB),
        .RESET_PB          (0),
        .RESET_HOLD_CYCLES (HLD),
        .PB_ACTIVE_LOW     (1),
        .LED_ACTIVE_LOW    (1),
        .PWM_BITS          (PB)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pb_in          (pb_in),
        .pb_level       (pb_level),
        .pb_press       (pb_press),
        .pb_release     (pb_release),
        .sys_reset      (sys_reset),
        .led_in         (led_in),
        .led_brightness (led_brightness),
        .led_out        (led_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [NPB-1:0] hist [0:63];   // pressed-normalised pin sampled at each edge
    int             edge_n     = 0;
    int             last_rst   = -1000;
    int             last_cause = -1000;
    int             phase      = 0;
    logic [NPB-1:0] m_level, m_press, m_rel;
    logic [LW-1:0]  m_led;
    bit             m_valid = 0;

    always @(posedge clk) begin
        bit ok;
        bit v;
        bit lit;
        edge_n++;
        // Record whether the cycle that just ended held a reset cause.
        if (!reset_n || m_level[0]) last_cause = edge_n - 1;
        if (!reset_n) begin
            last_rst = edge_n;
            m_level  = '0;
            m_press  = '0;
            m_rel    = '0;
            m_led    = '1;
            phase    = 0;
            m_valid  = 1;
        end else begin
            hist[edge_n % 64] = ~pb_in;
            for (int ch = 0; ch < NPB; ch++) begin
                // The level flips once the synchronised pin has shown the
                // opposite value for DB consecutive cycles. Pins sampled at or
                // before a reset edge count as released.
                ok = 1;
                for (int k = edge_n - SS - DB + 1; k <= edge_n - SS; k++) begin
                    v = (k <= last_rst) ? 1'b0 : hist[k % 64][ch];
                    if (v == m_level[ch]) ok = 0;
                end
                m_press[ch] = ok && !m_level[ch];
                m_rel[ch]   = ok && m_level[ch];
                if (ok) m_level[ch] = ~m_level[ch];
            end
            lit   = (led_brightness == 4'hF) || ((phase % 16) < int'(led_brightness));
            m_led = lit ? ~led_in : 8'hFF;
            phase++;
        end
    end

    always @(negedge clk) begin
        logic exp_sys;
        if (m_valid) begin
            exp_sys = !reset_n || m_level[0] || ((edge_n - last_cause) <= HLD);
            check("model_pb_level",   pb_level,   m_level);
            check("model_pb_press",   pb_press,   m_press);
            check("model_pb_release", pb_release, m_rel);
            check("model_sys_reset",  sys_reset,  exp_sys);
            check("model_led_out",    led_out,    m_led);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    // Advance one cycle. Inputs are then driven just after the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic count_sys_high(output int n);
        n = 0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (!sys_reset) break;
            n++;
            cyc();
        end
    endtask

    initial begin
        int n, found, pulses, bad, zeros;
        logic prev_sys;
        bit seen;

        reset_n        = 1'b0;
        pb_in          = 4'hF;
        led_in         = 8'h00;
        led_brightness = 4'h0;

        // 1. Reset values, then the sys_reset stretch after release.
        repeat (3) cyc();
        check("rst_pb_level", pb_level, 4'h0);
        check("rst_pulses", {pb_press, pb_release}, 8'h00);
        check("rst_sys_reset", sys_reset, 1'b1);
        check("rst_led_out", led_out, 8'hFF);
        reset_n = 1'b1;
        count_sys_high(n);
        check("rst_hold_cycles", n, 4);

        // 2. Bounce on button 1, then a steady press.
        pb_in[1] = 1'b0;
        repeat (5) cyc();
        pb_in[1] = 1'b1;
        cyc();
        pb_in[1] = 1'b0;
        found = 0; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            pulses += int'(pb_press[1]);
            if (pb_level[1] && found == 0) found = i;
        end
        check("press_latency", found, 10);
        check("press_pulse_count", pulses, 1);
        check("other_levels", pb_level, 4'b0010);

        // 3. Steady release, then a 7-cycle release glitch.
        pb_in[1] = 1'b1;
        found = 0; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            pulses += int'(pb_release[1]);
            if (!pb_level[1] && found == 0) found = i;
        end
        check("release_latency", found, 10);
        check("release_pulse_count", pulses, 1);
        pb_in[1] = 1'b0;
        repeat (15) cyc();
        check("repress_level", pb_level[1], 1'b1);
        pb_in[1] = 1'b1;
        repeat (7) cyc();
        pb_in[1] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            pulses += int'(pb_release[1]) + int'(pb_press[1]);
        end
        check("glitch_no_event", pulses, 0);
        check("glitch_level_kept", pb_level[1], 1'b1);
        pb_in[1] = 1'b1;
        repeat (15) cyc();

        // 4. Reset button: sys_reset follows pb_level[0], then holds 4 cycles.
        pb_in[0] = 1'b0;
        prev_sys = sys_reset;
        seen = 0; found = 0; bad = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (pb_level[0] && !seen) begin
                seen  = 1;
                found = i;
                check("sys_before_rise", prev_sys, 1'b0);
                check("sys_at_rise", sys_reset, 1'b1);
            end
            if (seen && !sys_reset) bad++;
            prev_sys = sys_reset;
        end
        check("resetpb_rise_latency", found, 10);
        check("sys_held_while_pressed", bad, 0);
        pb_in[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (!pb_level[0]) break;
        end
        check("resetpb_fell", pb_level[0], 1'b0);
        count_sys_high(n);
        check("resetpb_hold_cycles", n, 4);

        // Re-assertion of the cause two cycles into the hold restarts it.
        pb_in[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (pb_level[0]) break;
        end
        pb_in[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (!pb_level[0]) break;
        end
        cyc();
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        count_sys_high(n);
        check("hold_restart_cycles", n, 4);

        // 5. PWM brightness on LED 0.
        led_in = 8'h01;
        led_brightness = 4'd4;
        repeat (2) cyc();
        zeros = 0; bad = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            zeros += int'(!led_out[0]);
            if (led_out[7:1] != 7'h7F) bad++;
        end
        check("pwm_duty_4", zeros, 4);
        led_brightness = 4'd15;
        repeat (2) cyc();
        zeros = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            zeros += int'(!led_out[0]);
            if (led_out[7:1] != 7'h7F) bad++;
        end
        check("pwm_duty_15", zeros, 16);
        led_brightness = 4'd0;
        repeat (2) cyc();
        zeros = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            zeros += int'(!led_out[0]);
            if (led_out[7:1] != 7'h7F) bad++;
        end
        check("pwm_duty_0", zeros, 0);
        check("pwm_unlit_leds", bad, 0);

        // 6. Reset in the middle of a debounce discards the count.
        pb_in[2] = 1'b0;
        repeat (7) cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (pb_press[2] && found == 0) found = i;
        end
        check("midreset_press_latency", found, 10);
        pb_in[2] = 1'b1;
        repeat (15) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
- Parametrised board-level I/O front end between raw board pins and the SimpleCPU core.
- Replaces the fixed two-flop push-button reset and hard-wired LED inversion.
- Provides per-channel synchronised, debounced push buttons with press/release event pulses.
- Generates a stretched active-high system reset from reset_n or a designated button, and drives an LED bank with selectable polarity and global PWM brightness.

Parameters:
NUM_PB, 4, number of push-button channels (1..16)
LED_WIDTH, 8, number of LED outputs
SYNC_STAGES, 2, synchroniser flop count per button (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a level change (>=2)
RESET_PB, 0, index of the button that triggers sys_reset
RESET_HOLD_CYCLES, 16, sys_reset stretch after release of its cause (>=1)
PB_ACTIVE_LOW, 1, 1 = button pin reads 0 when pressed
LED_ACTIVE_LOW, 1, 1 = LED pin driven 0 to light
PWM_BITS, 4, brightness resolution

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
pb_in  input  NUM_PB  raw asynchronous button pins
pb_level  output  NUM_PB  debounced level, 1 = pressed
pb_press  output  NUM_PB  one-cycle pulse when pb_level rises
pb_release  output  NUM_PB  one-cycle pulse when pb_level falls
sys_reset  output  1  active-high reset to the core
led_in  input  LED_WIDTH  logical LED state from the core, 1 = lit
led_brightness  input  PWM_BITS  global duty setting
led_out  output  LED_WIDTH  LED pins, board polarity

Behaviour:
- Clock and reset: one clock domain. reset_n is synchronous and active-low. All registers update on the rising edge of clk.
- Reset values while reset_n = 0:
  - Synchroniser flops hold the not-pressed pin level.
  - Debounce counters = 0; pb_level = 0; pb_press = pb_release = 0.
  - sys_reset = 1; hold counter = 0.
  - PWM counter = 0; led_out = all unlit (all 1 when LED_ACTIVE_LOW = 1).
- Synchroniser:
  - SYNC_STAGES flops per channel.
  - Output is normalised to pressed = 1 by XOR with PB_ACTIVE_LOW.
- Debounce, per channel:
  - If the synchronised value equals pb_level, the counter clears.
  - Otherwise the counter increments.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 while still differing, the next edge sets pb_level to the synchronised value and clears the counter.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and produces no event.
  - Latency from a steady pin change to pb_level change = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - Counter width is clog2(DEBOUNCE_CYCLES); it never wraps.
- Events:
  - pb_press and pb_release are registered and asserted for exactly the first cycle in which pb_level shows the new value.
  - Press and release never coincide on the same channel.
  - Channels are fully independent; simultaneous events on several channels are all reported.
- Reset generator:
  - The cause is active while reset_n = 0 or pb_level[RESET_PB] = 1.
  - sys_reset = 1 while the cause is active. pb_level[RESET_PB] rising asserts sys_reset on that same cycle (combinational OR with the hold state, no extra delay).
  - After the cause clears, sys_reset stays 1 for exactly RESET_HOLD_CYCLES further cycles, then drops to 0.
  - Re-assertion during the hold restarts the full hold.
  - pb_press and pb_release are still reported for RESET_PB.
- LED PWM:
  - A free-running PWM_BITS counter increments every cycle and wraps naturally.
  - The lit condition is: led_brightness = all-ones, or PWM counter < led_brightness.
  - led_brightness = 0 means always off. All-ones means always on.
  - led_out[i] is registered as (led_in[i] AND lit) XOR LED_ACTIVE_LOW, giving 1-cycle latency from led_in.
  - led_brightness is sampled every cycle, so changes take effect mid-period.
- Reset mid-operation: asserting reset_n = 0 during debounce discards the count, so no event fires after reset release unless the pin change persists for a full new debounce period.

Test Plan:
Test parameters: DEBOUNCE_CYCLES=8, RESET_HOLD_CYCLES=4, SYNC_STAGES=2, PWM_BITS=4, defaults otherwise.
1. Reset: reset_n = 0 for 3 cycles, pb_in = 4'hF -> pb_level = 0, pulses = 0, sys_reset = 1, led_out = 8'hFF. Release reset_n -> sys_reset stays 1 for exactly 4 cycles, then 0.
2. Bounce: pb_in[1] low 5 cycles, high 1, then low steady -> pb_level[1] rises exactly 10 cycles after the final low edge. pb_press[1] is a single 1-cycle pulse. No other channel toggles.
3. Release: pb_in[1] returns high steady -> pb_release[1] pulses once, 10 cycles later. A 7-cycle high glitch instead -> no event.
4. Reset button: pb_in[0] low 30 cycles -> sys_reset rises on the cycle pb_level[0] rises, holds while pressed, and falls 4 cycles after pb_level[0] falls. A re-press during the hold restarts the hold.
5. PWM: led_in = 8'h01.
   - led_brightness = 4 -> led_out[0] = 0 for 4 of every 16 cycles.
   - led_brightness = 15 -> always 0.
   - led_brightness = 0 -> always 1.
   - led_out[7:1] = 1 throughout.
6. Mid-debounce reset: pb_in[2] low, reset_n pulsed low at count 5 -> no pb_press[2] until 10 full cycles after reset_n returns high.
